// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the TX arbiter state encoding.
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } tx_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: first asserted request after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             any_gnt
);

  logic [IDW-1:0]   cand_id [N_REQ];
  logic [N_REQ-1:0] hit;

  // Candidate gi is the requester (gi+1) places after ptr; ptr < N_REQ so one wrap suffices.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum         = {1'b0, ptr} + (IDW+1)'(gi + 1);
    assign cand_id[gi] = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ)) : IDW'(sum);
    assign hit[gi]     = req[cand_id[gi]];
  end

  always_comb begin
    gnt_id  = '0;
    any_gnt = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        gnt_id  = cand_id[k];
        any_gnt = 1'b1;
      end
    end
    gnt         = '0;
    gnt[gnt_id] = any_gnt;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for a single uart_transmitter; frame length is timed locally
// so the transmitter needs no busy/done feedback.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = uart_pkg::DATA_W,
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BITS   = uart_pkg::FRAME_BITS
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_start_transmission,
  output logic                      o_busy,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id
);

  import uart_pkg::*;

  localparam int IDW       = $clog2(N_REQ);
  localparam int FRAME_CYC = CLKS_PER_BIT * FRAME_BITS;
  localparam int TW        = $clog2(FRAME_CYC);
  localparam logic [TW-1:0] RELOAD = TW'(FRAME_CYC - 1);

  tx_arb_state_t state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDW-1:0]    arb_gnt_id;
  logic              arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req     (i_req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_id  (arb_gnt_id),
    .any_gnt (arb_any)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          data_d  = i_req_data[arb_gnt_id*DATA_W +: DATA_W];
          grant_d = arb_gnt_id;
          ptr_d   = arb_gnt_id;
          busy_d  = 1'b1;
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        timer_d = RELOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (timer_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= IDW'(N_REQ - 1);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
    end
  end

  // Ready is offered only in IDLE and never while reset is held.
  assign o_req_ready          = (state_q == IDLE && i_reset) ? arb_gnt : '0;
  assign o_data               = data_q;
  assign o_start_transmission = start_q;
  assign o_busy               = busy_q;
  assign o_grant_id           = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed round-robin vectors plus frame-timing sequences.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [3:0]      valid;
  logic [31:0]     data_bus;
  logic [3:0]      o_req_ready;
  logic [7:0]      o_data;
  logic            o_start_transmission;
  logic            o_busy;
  logic [1:0]      o_grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .DATA_W       (DW),
    .CLKS_PER_BIT (16),
    .FRAME_BITS   (10)
  ) dut (
    .clk                  (clk),
    .i_reset              (i_reset),
    .i_req_valid          (valid),
    .i_req_data           (data_bus),
    .o_req_ready          (o_req_ready),
    .o_data               (o_data),
    .o_start_transmission (o_start_transmission),
    .o_busy               (o_busy),
    .o_grant_id           (o_grant_id)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int gid; logic [7:0] data; } exp_t;
  exp_t exp_q[$];
  int   start_cnt = 0;
  int   start_cyc[$];

  typedef struct { logic [3:0] valid; int gid; } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int gid, input logic [7:0] d);
    exp_t e;
    e.gid  = gid;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Start-pulse monitor: pops the scoreboard and checks o_data stays put for the frame.
  initial begin
    exp_t e;
    logic [7:0] frame_data;
    bit data_moved;
    logic prev_busy;
    frame_data = '0;
    data_moved = 1'b0;
    prev_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (o_start_transmission === 1'b1) begin
        start_cnt++;
        start_cyc.push_back(cyc);
        frame_data = o_data;
        data_moved = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("start_grant_id", o_grant_id, e.gid);
          check("start_data", o_data, e.data);
          $display("frame start cycle=%0d grant=%0d data=%02h", cyc, o_grant_id, o_data);
        end
      end else if (o_busy === 1'b1 && o_data !== frame_data) begin
        data_moved = 1'b1;
      end
      if (prev_busy === 1'b1 && o_busy === 1'b0 && i_reset === 1'b1)
        check("data_stable", data_moved, 0);
      prev_busy = o_busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a negedge with valid driven; waits for ready, checks it, then lets the edge transfer.
  task automatic accept(input string name, input logic [3:0] exp_ready, input logic [3:0] valid_after);
    int n = 0;
    while (o_req_ready == 4'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready"}, o_req_ready, exp_ready);
    tick();
    valid = valid_after;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (o_busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (o_busy !== 1'b0) check({name, "_busy_timeout"}, o_busy, 0);
    tick();
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (start_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (start_cnt < target) check("start_timeout", start_cnt, target);
  endtask

  initial begin
    int  n;
    int  base;
    bit  early;
    bit  seen;

    // Pointer after the single-request test is 0; gids follow the rotate-from-ptr+1 rule.
    vecs[0] = '{4'b1111, 1};
    vecs[1] = '{4'b0001, 0};
    vecs[2] = '{4'b1000, 3};
    vecs[3] = '{4'b1010, 1};
    vecs[4] = '{4'b0011, 0};
    vecs[5] = '{4'b1100, 2};
    vecs[6] = '{4'b0110, 1};
    vecs[7] = '{4'b0010, 1};

    // Reset with every requester asking
    i_reset  = 1'b0;
    valid    = 4'b1111;
    data_bus = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", o_req_ready, 0);
    check("reset_start", o_start_transmission, 0);
    check("reset_busy", o_busy, 0);
    check("reset_data", o_data, 0);
    check("reset_grant_id", o_grant_id, 0);
    valid = 4'b0000;
    tick();
    i_reset = 1'b1;

    // Single request: frame length and start latency
    data_bus[7:0] = 8'hF0;
    valid = 4'b0001;
    push_exp(0, 8'hF0);
    @(negedge clk);
    accept("single", 4'b0001, 4'b0000);
    @(negedge clk);
    check("single_start_next", o_start_transmission, 1);
    check("single_ready_in_start", o_req_ready, 0);
    n = 0;
    while (o_busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("single_busy_len", n, 161);
    check("single_start_count", start_cnt, 1);
    tick();

    // Table of one-shot requests
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 4; r++) data_bus[r*8 +: 8] = 8'(8'hA0 + i*4 + r);
      valid = vecs[i].valid;
      push_exp(vecs[i].gid, 8'(8'hA0 + i*4 + vecs[i].gid));
      @(negedge clk);
      accept($sformatf("vec%0d", i), 4'(1 << vecs[i].gid), 4'b0000);
      wait_idle($sformatf("vec%0d", i));
    end

    // Fairness from a fresh pointer with all requesters held
    i_reset = 1'b0;
    repeat (2) tick();
    i_reset = 1'b1;
    data_bus = 32'h13121110;
    base = start_cnt;
    push_exp(0, 8'h10);
    push_exp(1, 8'h11);
    push_exp(2, 8'h12);
    push_exp(3, 8'h13);
    push_exp(0, 8'h10);
    valid = 4'b1111;
    wait_starts(base + 5);
    valid = 4'b0000;
    wait_idle("fair");
    if (start_cyc.size() >= base + 5)
      for (int k = 1; k < 5; k++)
        check($sformatf("fair_spacing%0d", k), start_cyc[base+k] - start_cyc[base+k-1], 162);

    // Requests arriving mid-WAIT wait for IDLE and follow the pointer
    data_bus[23:16] = 8'h22;
    valid = 4'b0100;
    push_exp(2, 8'h22);
    @(negedge clk);
    accept("ptr_g2", 4'b0100, 4'b0000);
    repeat (50) @(negedge clk);
    data_bus[7:0]  = 8'h30;
    data_bus[15:8] = 8'h31;
    valid = 4'b0011;
    push_exp(0, 8'h30);
    push_exp(1, 8'h31);
    early = 1'b0;
    n = 0;
    while (o_busy === 1'b1 && n < 400) begin
      if (o_req_ready != 4'b0) early = 1'b1;
      @(negedge clk);
      n++;
    end
    check("ptr_no_early_grant", early, 0);
    accept("ptr_g0", 4'b0001, 4'b0010);
    @(negedge clk);
    accept("ptr_g1", 4'b0010, 4'b0000);
    wait_idle("ptr");

    // Reset in the middle of a frame
    data_bus[7:0]   = 8'h50;
    data_bus[31:24] = 8'h53;
    valid = 4'b1001;
    push_exp(3, 8'h53);
    @(negedge clk);
    accept("rst_g3", 4'b1000, 4'b1001);
    repeat (50) @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy_low", o_busy, 0);
    check("rst_ready_low", o_req_ready, 0);
    check("rst_start_low", o_start_transmission, 0);
    tick();
    i_reset = 1'b1;
    push_exp(0, 8'h50);
    push_exp(3, 8'h53);
    @(negedge clk);
    accept("rst_g0", 4'b0001, 4'b1000);
    @(negedge clk);
    accept("rst_g3b", 4'b1000, 4'b0000);
    wait_idle("rst");

    // Request pulsed only during WAIT is never seen
    data_bus[23:16] = 8'h66;
    valid = 4'b0100;
    push_exp(2, 8'h66);
    @(negedge clk);
    accept("wd_g2", 4'b0100, 4'b0000);
    repeat (30) @(negedge clk);
    valid = 4'b0001;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_req_ready != 4'b0) seen = 1'b1;
    end
    valid = 4'b0000;
    check("wd_no_ready", seen, 0);
    base = start_cnt;
    wait_idle("wd");
    repeat (200) tick();
    check("wd_no_extra_start", start_cnt, base);
    for (int r = 0; r < 4; r++) data_bus[r*8 +: 8] = 8'(8'h70 + r);
    valid = 4'b1111;
    push_exp(3, 8'h73);
    @(negedge clk);
    accept("wd_ptr", 4'b1000, 4'b0000);
    wait_idle("wd_ptr");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
